// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
package serial_add_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Bits needed to count 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/singlebit_full_adder.sv
// One-bit full-adder cell; the serial datapath reuses it once per clock.
module singlebit_full_adder (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/serial_add_sub_seq.sv
// Bit-serial WIDTH-bit add/sub, LSB first, one bit per clock through a single full-adder cell.
// Optional zero-result flag output enabled by defining SERIAL_ADD_ZERO_FLAG_EN.
module serial_add_sub_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
`ifdef SERIAL_ADD_ZERO_FLAG_EN
  output logic             zero,
`endif
  output logic             overflow
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [WIDTH-1:0] sum_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             busy_q, done_q, cout_q, ovf_q;
  logic             cell_s, cell_c;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
  logic             any_q, zero_q;
`endif

  singlebit_full_adder u_cell (
    .a         (a_q[0]),
    .b         (b_q[0]),
    .carry_in  (carry_q),
    .sum       (cell_s),
    .carry_out (cell_c)
  );

  assign sum_d = {cell_s, sum_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
      any_q   <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub;
            cnt_q   <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b1;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
            any_q   <= 1'b0;
`endif
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          sum_q   <= sum_d;
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= cell_c;
          cnt_q   <= cnt_q + CW'(1);
`ifdef SERIAL_ADD_ZERO_FLAG_EN
          any_q   <= any_q | cell_s;
`endif
          if (cnt_q == LAST) begin
            // On the MSB step the carry flop already holds the carry into the MSB.
            cout_q  <= cell_c;
            ovf_q   <= carry_q ^ cell_c;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
            zero_q  <= ~(any_q | cell_s);
`endif
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
  assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_serial_add_sub_seq.sv
// Scoreboard bench for serial_add_sub_seq at WIDTH=32 and WIDTH=8 (zero flag checked when SERIAL_ADD_ZERO_FLAG_EN).
module tb_serial_add_sub_seq;

  typedef struct {
    logic [31:0] sum;
    logic        c;
    logic        v;
    logic        z;
    int unsigned cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start32 = 1'b0, sub32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0, sum32;
  logic        busy32, done32, c32, v32;
  logic        start8 = 1'b0, sub8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, sum8;
  logic        busy8, done8, c8, v8;
`ifdef SERIAL_ADD_ZERO_FLAG_EN
  logic        z32, z8;
`endif

  serial_add_sub_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .sub(sub32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .sum(sum32), .carry_out(c32),
`ifdef SERIAL_ADD_ZERO_FLAG_EN
    .zero(z32),
`endif
    .overflow(v32)
  );

  serial_add_sub_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(c8),
`ifdef SERIAL_ADD_ZERO_FLAG_EN
    .zero(z8),
`endif
    .overflow(v8)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int dones32  = 0;
  exp_t q32[$];
  exp_t q8[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    if (!rst && done32) begin
      exp_t e;
      dones32++;
      if (q32.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done32: done=1 with nothing outstanding (cycle %0d)", cyc);
      end else begin
        e = q32.pop_front();
        check("sum32", sum32, e.sum);
        check("carry32", {31'd0, c32}, {31'd0, e.c});
        check("ovf32", {31'd0, v32}, {31'd0, e.v});
        check("done_cycle32", cyc, e.cyc);
        check("busy_at_done32", {31'd0, busy32}, 32'd1);
`ifdef SERIAL_ADD_ZERO_FLAG_EN
        check("zero32", {31'd0, z32}, {31'd0, e.z});
`endif
        $display("txn w32: sum=%08h c=%0b v=%0b at cycle %0d", sum32, c32, v32, cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done8) begin
      exp_t e;
      if (q8.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done8: done=1 with nothing outstanding (cycle %0d)", cyc);
      end else begin
        e = q8.pop_front();
        check("sum8", {24'd0, sum8}, e.sum);
        check("carry8", {31'd0, c8}, {31'd0, e.c});
        check("ovf8", {31'd0, v8}, {31'd0, e.v});
        check("done_cycle8", cyc, e.cyc);
`ifdef SERIAL_ADD_ZERO_FLAG_EN
        check("zero8", {31'd0, z8}, {31'd0, e.z});
`endif
        $display("txn w8: sum=%02h c=%0b v=%0b at cycle %0d", sum8, c8, v8, cyc);
      end
    end
  end

  // Issue one operation, push its expectation, then wait out the full operation.
  task automatic run_op(input bit w8, input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] es, input logic ec, input logic ev, input logic ez);
    exp_t e;
    int   w;
    w = w8 ? 8 : 32;
    @(negedge clk);
    e.sum = es; e.c = ec; e.v = ev; e.z = ez;
    e.cyc = cyc + 1 + w;
    if (w8) begin
      a8 = a[7:0]; b8 = b[7:0]; sub8 = s; start8 = 1'b1; q8.push_back(e);
    end else begin
      a32 = a; b32 = b; sub32 = s; start32 = 1'b1; q32.push_back(e);
    end
    @(negedge clk);
    start8 = 1'b0;
    start32 = 1'b0;
    repeat (w + 1) @(negedge clk);
    check(w8 ? "drained8" : "drained32", w8 ? q8.size() : q32.size(), 32'd0);
  endtask

  initial begin
    int d_before;
    repeat (3) @(negedge clk);
    check("rst_busy32", {31'd0, busy32}, 32'd0);
    check("rst_done32", {31'd0, done32}, 32'd0);
    check("rst_sum32", sum32, 32'd0);
    check("rst_flags32", {30'd0, c32, v32}, 32'd0);
    check("rst_sum8", {24'd0, sum8}, 32'd0);
    rst = 1'b0;

    run_op(0, 32'd5,         32'd7, 0, 32'd12,        0, 0, 0);
    run_op(0, 32'hFFFF_FFFF, 32'd1, 0, 32'd0,         1, 0, 1);
    run_op(0, 32'h7FFF_FFFF, 32'd1, 0, 32'h8000_0000, 0, 1, 0);
    run_op(0, 32'd5,         32'd7, 1, 32'hFFFF_FFFE, 0, 0, 0);
    run_op(0, 32'd7,         32'd5, 1, 32'd2,         1, 0, 0);
    run_op(0, 32'h8000_0000, 32'd1, 1, 32'h7FFF_FFFF, 1, 1, 0);
    run_op(0, 32'd9,         32'd9, 1, 32'd0,         1, 0, 1);

    // Extra start pulses while busy must be ignored.
    begin
      exp_t e;
      @(negedge clk);
      a32 = 32'h1234_5678; b32 = 32'h1111_1111; sub32 = 1'b0; start32 = 1'b1;
      e.sum = 32'h2345_6789; e.c = 0; e.v = 0; e.z = 0; e.cyc = cyc + 33;
      q32.push_back(e);
      for (int i = 1; i <= 40; i++) begin
        @(negedge clk);
        start32 = (i == 3 || i == 10 || i == 20);
        if (start32) begin
          a32 = 32'hDEAD_0000 + i; b32 = 32'h0F0F_0F0F; sub32 = 1'b1;
        end
      end
      check("ignored_starts_drained", q32.size(), 32'd0);
      check("sum_held_after_done", sum32, 32'h2345_6789);
    end

    // Reset mid-run with a simultaneous start: operation discarded, no done.
    @(negedge clk);
    a32 = 32'hAAAA_5555; b32 = 32'h1234_0000; sub32 = 1'b0; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (14) @(negedge clk);
    check("busy_before_rst", {31'd0, busy32}, 32'd1);
    rst = 1'b1; start32 = 1'b1;
    @(negedge clk);
    rst = 1'b0; start32 = 1'b0;
    check("rst_mid_busy", {31'd0, busy32}, 32'd0);
    check("rst_mid_sum", sum32, 32'd0);
    check("rst_mid_flags", {30'd0, c32, v32}, 32'd0);
    d_before = dones32;
    repeat (40) @(negedge clk);
    check("no_done_after_rst", dones32, d_before);
    check("idle_after_rst", {31'd0, busy32}, 32'd0);

    run_op(1, 32'h80, 32'h01, 1, 32'h7F, 1, 1, 0);
    run_op(1, 32'hFF, 32'h01, 0, 32'h00, 1, 0, 1);
    run_op(1, 32'h40, 32'h40, 0, 32'h80, 0, 1, 0);
    run_op(0, 32'd5,  32'd7,  0, 32'd12, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
